serial_chunk_adder: RTL and testbench
=====================================

SERIAL_CHUNK_ADDER -- requirements
Module: serial_chunk_adder

Interface
REQ-001 Parameter WIDTH, default 16: operand and result width in bits.
REQ-002 Parameter CHUNK, default 4: bits added per clock cycle; WIDTH SHALL be an integer multiple of CHUNK, with 1 <= CHUNK <= WIDTH.
REQ-003 Derived constant N = WIDTH/CHUNK SHALL be the number of processing cycles per operation.
REQ-004 Ports SHALL be as follows; one clock; reset is asynchronous and active-low.
  clk    in   1      rising-edge clock
  rst_n  in   1      asynchronous active-low reset
  start  in   1      request a new operation (sampled only in IDLE)
  A      in   WIDTH  operand A
  B      in   WIDTH  operand B
  Cin    in   1      carry-in (used when sub=0)
  sub    in   1      0: A+B+Cin; 1: A-B
  S      out  WIDTH  result
  Cout   out  1      carry out of the MSB
  V      out  1      two's-complement overflow
  busy   out  1      operation in progress
  done   out  1      one-cycle result-valid pulse

Function
REQ-005 The FSM SHALL have exactly three states, IDLE, RUN and DONE.
  - IDLE -> RUN on start=1.
  - RUN -> DONE after the N-th chunk.
  - DONE -> IDLE unconditionally after one cycle.
REQ-006 On the accepting edge (IDLE, start=1), the block SHALL latch the operands and carry.
  - Latched: A, B' = sub ? ~B : B, carry = sub ? 1 : Cin, and sub.
  - A chunk counter SHALL be cleared to 0.
REQ-007 In RUN, each rising edge SHALL add chunk k (bits [k*CHUNK +: CHUNK]) of A and B' plus the stored carry.
  - The chunk sum goes to an internal accumulator; the chunk carry-out is stored for the next chunk.
  - Chunks are processed LSB first, k = 0..N-1.
REQ-008 done SHALL be 1 only in DONE, exactly N rising edges after the accepting edge; done is never high for more than one consecutive cycle.
REQ-009 busy SHALL be 1 exactly while the state is RUN.
REQ-010 S, Cout and V SHALL update only on the edge that enters DONE, and SHALL hold until the next such edge or reset; partial sums are never visible on S.
REQ-011 S SHALL equal (A + B' + carry) mod 2^WIDTH for the latched values.
REQ-012 Cout SHALL equal the carry out of bit WIDTH-1. With sub=1, Cout=1 SHALL mean unsigned A >= B (no borrow).
REQ-013 V SHALL be 1 iff A[WIDTH-1] == B'[WIDTH-1] and S[WIDTH-1] != A[WIDTH-1].
REQ-014 start SHALL be ignored in RUN and DONE; A, B, Cin and sub SHALL be ignored at all times except on the accepting edge.
REQ-015 start=1 held continuously SHALL produce back-to-back operations: a new operation is accepted in IDLE one cycle after each done.
REQ-016 With CHUNK=WIDTH (N=1), the block SHALL spend one cycle in RUN, and done SHALL assert 1 edge after acceptance.
REQ-017 Carry SHALL propagate across all chunk boundaries; a carry from chunk k is consumed by chunk k+1 on the next edge.

Reset
REQ-018 rst_n=0 SHALL immediately, without waiting for a clock edge, force the following.
  - State: IDLE.
  - Outputs: S=0, Cout=0, V=0, busy=0, done=0.
  - Internal state: accumulator, carry and chunk counter cleared to 0.
REQ-019 Reset asserted during RUN or DONE SHALL abort the operation: no done pulse follows, and the aborted result is never presented.
REQ-020 After rst_n deasserts, the block SHALL remain in IDLE until start=1 is sampled on a rising edge.

Verification (WIDTH=16, CHUNK=4, N=4)
REQ-021 A=0x1234, B=0x1111, Cin=1, sub=0 -> done 4 edges after accept; S=0x2346, Cout=0, V=0; busy high for 4 cycles.
REQ-022 A=0xFFFF, B=0x0001, Cin=0, sub=0 -> S=0x0000, Cout=1, V=0 (carry ripples through all 4 chunks).
REQ-023 A=0x7FFF, B=0x0001, Cin=0, sub=0 -> S=0x8000, Cout=0, V=1. Then A=0x0005, B=0x0007, sub=1, Cin=1 -> S=0xFFFE, Cout=0, V=0.
REQ-024 A=0x8000, B=0x0001, sub=1 -> S=0x7FFF, Cout=1, V=1.
REQ-025 Accept A=0x0001, B=0x0001, then pulse start with A=0xAAAA, B=0x5555 during RUN and DONE -> single done; S=0x0002; second request ignored.
REQ-026 rst_n low at the 2nd RUN cycle -> S, Cout, V, busy and done all 0 immediately; no done after release; a following start with A=0x0003, B=0x0004 yields S=0x0007.

Source files
------------

// File: rtl/serial_chunk_adder.sv
// Multi-cycle adder/subtractor: adds CHUNK bits per clock, LSB chunk first,
// and presents the registered result with a one-cycle done pulse.
module serial_chunk_adder #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    input  logic             sub,
    output logic [WIDTH-1:0] S,
    output logic             Cout,
    output logic             V,
    output logic             busy,
    output logic             done
);

    localparam int unsigned N     = WIDTH / CHUNK;
    localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned SUM_W = CHUNK + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [WIDTH-1:0]   acc;
    logic               carry;
    logic [CNT_W-1:0]   cnt;

    logic [SUM_W-1:0]   chunk_sum;
    logic [WIDTH-1:0]   acc_next;
    logic               last;

    // Current chunk sum and the accumulator with that chunk merged in
    always_comb begin
        chunk_sum = {1'b0, a_q[int'(cnt) * CHUNK +: CHUNK]}
                  + {1'b0, b_q[int'(cnt) * CHUNK +: CHUNK]}
                  + SUM_W'(carry);
        acc_next  = acc;
        acc_next[int'(cnt) * CHUNK +: CHUNK] = chunk_sum[CHUNK-1:0];
        last      = (cnt == CNT_W'(N - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            a_q   <= '0;
            b_q   <= '0;
            acc   <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            S     <= '0;
            Cout  <= 1'b0;
            V     <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_q   <= A;
                        b_q   <= sub ? ~B : B;
                        carry <= sub ? 1'b1 : Cin;
                        cnt   <= '0;
                        acc   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    acc   <= acc_next;
                    carry <= chunk_sum[CHUNK];
                    if (last) begin
                        // Result becomes visible only here; partial sums stay internal
                        S     <= acc_next;
                        Cout  <= chunk_sum[CHUNK];
                        V     <= (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                                 (acc_next[WIDTH-1] != a_q[WIDTH-1]);
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_chunk_adder.sv
// Directed self-checking bench for serial_chunk_adder (WIDTH=16, CHUNK=4).
module tb_serial_chunk_adder;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] A;
    logic [15:0] B;
    logic        Cin;
    logic        sub;
    logic [15:0] S;
    logic        Cout;
    logic        V;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;

    serial_chunk_adder #(.WIDTH(16), .CHUNK(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .A     (A),
        .B     (B),
        .Cin   (Cin),
        .sub   (sub),
        .S     (S),
        .Cout  (Cout),
        .V     (V),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Issue one operation and check latency, busy width, result and pulse width
    task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic cin, input logic sb,
                          input logic [15:0] exp_s, input logic exp_c, input logic exp_v);
        int cycles;
        int busy_cnt;
        @(negedge clk);
        A = a; B = b; Cin = cin; sub = sb; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        A = 16'hDEAD; B = 16'hBEEF; Cin = ~cin; sub = ~sb;
        cycles = 0;
        busy_cnt = 0;
        while (!done && cycles < 20) begin
            if (busy) busy_cnt++;
            @(negedge clk);
            cycles++;
        end
        check({tag, " latency"}, 32'(cycles), 32'd4);
        check({tag, " busy_cycles"}, 32'(busy_cnt), 32'd4);
        check({tag, " S"}, 32'(S), 32'(exp_s));
        check({tag, " Cout"}, 32'(Cout), 32'(exp_c));
        check({tag, " V"}, 32'(V), 32'(exp_v));
        check({tag, " busy_at_done"}, 32'(busy), 32'd0);
        @(negedge clk);
        check({tag, " done_one_cycle"}, 32'(done), 32'd0);
        check({tag, " S_hold"}, 32'(S), 32'(exp_s));
    endtask

    // Watch for a given number of cycles that done stays low and the block idles
    task automatic quiet(input string tag, input int n);
        int seen_done;
        int seen_busy;
        seen_done = 0;
        seen_busy = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (done) seen_done++;
            if (busy) seen_busy++;
        end
        check({tag, " no_done"}, 32'(seen_done), 32'd0);
        check({tag, " no_busy"}, 32'(seen_busy), 32'd0);
    endtask

    initial begin
        int cycles;
        int gap;
        rst_n = 1'b0;
        start = 1'b0;
        A = '0; B = '0; Cin = 1'b0; sub = 1'b0;
        #1;
        check("reset S", 32'(S), 32'd0);
        check("reset Cout", 32'(Cout), 32'd0);
        check("reset V", 32'(V), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        quiet("idle_after_reset", 3);

        run_op("add_cin",    16'h1234, 16'h1111, 1'b1, 1'b0, 16'h2346, 1'b0, 1'b0);
        run_op("ripple_all", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        run_op("add_ovf",    16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        run_op("sub_borrow", 16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        run_op("sub_ovf",    16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
        run_op("mid_carry",  16'h00FF, 16'h0F01, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0);

        // start pulses during RUN and DONE must be ignored
        @(negedge clk);
        A = 16'h0001; B = 16'h0001; Cin = 1'b0; sub = 1'b0; start = 1'b1;
        @(negedge clk);
        A = 16'hAAAA; B = 16'h5555;
        cycles = 0;
        while (!done && cycles < 20) begin
            @(negedge clk);
            cycles++;
        end
        check("ignore_start latency", 32'(cycles), 32'd4);
        check("ignore_start S", 32'(S), 32'h0002);
        @(negedge clk);
        start = 1'b0;
        quiet("ignore_start", 8);
        check("ignore_start S_hold", 32'(S), 32'h0002);

        // start held high gives back-to-back operations, done every 6 cycles
        @(negedge clk);
        A = 16'h0010; B = 16'h0020; Cin = 1'b0; sub = 1'b0; start = 1'b1;
        cycles = 0;
        while (!done && cycles < 20) begin
            @(negedge clk);
            cycles++;
        end
        gap = 0;
        @(negedge clk);
        gap++;
        while (!done && gap < 20) begin
            @(negedge clk);
            gap++;
        end
        start = 1'b0;
        check("b2b gap", 32'(gap), 32'd6);
        check("b2b S", 32'(S), 32'h0030);
        repeat (8) @(negedge clk);

        // reset in the 2nd RUN cycle aborts the operation immediately
        @(negedge clk);
        A = 16'h0F0F; B = 16'h0101; Cin = 1'b0; sub = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check("abort busy_before", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("abort S", 32'(S), 32'd0);
        check("abort Cout", 32'(Cout), 32'd0);
        check("abort V", 32'(V), 32'd0);
        check("abort busy", 32'(busy), 32'd0);
        check("abort done", 32'(done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        quiet("abort", 8);
        check("abort S_after", 32'(S), 32'd0);
        run_op("after_abort", 16'h0003, 16'h0004, 1'b0, 1'b0, 16'h0007, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
